// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB master arbiter.
// State encoding and APB address/data widths.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 3;
  localparam int APB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Returns the first requesting line at or after ptr_i.
module rr_priority_picker
  import apb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  // Walk offsets from the pointer, take the first hit
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid_o && req_i[j] &&
            (((int'(ptr_i) + i) % N) == j)) begin
          gnt_o[j] = 1'b1;
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter in front of one APB master port.
// Optional ACCESS timeout: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [APB_DATA_W-1:0]         rdata,
  output logic [APB_ADDR_W-1:0]         paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [APB_DATA_W-1:0]         pwdata,
  input  logic                          pready,
  input  logic [APB_DATA_W-1:0]         prdata
);

  localparam int PW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master_arbiter: bad parameters");
  end

  apb_state_e            state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic [APB_DATA_W-1:0] pwdata_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic                  pick_vld;
  logic [APB_ADDR_W-1:0] sel_addr;
  logic                  sel_wr;
  logic [APB_DATA_W-1:0] sel_wd;
  logic [PW-1:0]         sel_idx;
  logic                  tmo;
  logic                  fin;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_vld)
  );

  // Mux the winner's command and compute the next pointer
  always_comb begin
    sel_addr = '0;
    sel_wr   = 1'b0;
    sel_wd   = '0;
    sel_idx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_gnt[j]) begin
        sel_addr = req_addr[j*APB_ADDR_W +: APB_ADDR_W];
        sel_wr   = req_write[j];
        sel_wd   = req_wdata[j*APB_DATA_W +: APB_DATA_W];
        sel_idx  = PW'(j);
      end
    end
    ptr_d = (sel_idx == PW'(NUM_REQ - 1)) ?
            '0 : sel_idx + 1'b1;
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign tmo = (state_q == ACCESS) && !pready &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count ACCESS wait cycles, cleared on entry
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !pready && !tmo) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign fin = (state_q == ACCESS) && pready;

  // Completion response goes only to the locked grant
  always_comb begin
    done  = (fin || tmo) ? grant_q : '0;
    rdata = fin ? prdata : '0;
    err   = tmo;
  end

  // APB master FSM with registered bus outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            grant_q   <= pick_gnt;
            paddr_q   <= sel_addr;
            pwrite_q  <= sel_wr;
            pwdata_q  <= sel_wd;
            ptr_q     <= ptr_d;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (fin || tmo) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the APB master port (2..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles (used only with APB_ARB_TIMEOUT_EN).
REQ-003 pclk  input  1  APB clock; all logic on rising edge.
REQ-004 preset  input  1  reset: asynchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester transfer request; held high with stable command until done.
REQ-006 req_addr  input  NUM_REQ x 3  per-requester register address.
REQ-007 req_write  input  NUM_REQ  per-requester direction, 1 = write.
REQ-008 req_wdata  input  NUM_REQ x 16  per-requester write data.
REQ-009 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 err  output  1  timeout flag, valid only while any done bit is high.
REQ-011 rdata  output  16  read data, valid only while any done bit is high.
REQ-012 paddr, psel, penable, pwrite, pwdata  output  3/1/1/1/16  APB master request signals.
REQ-013 pready, prdata  input  1/16  APB slave response signals.

Function
REQ-014 FSM states: IDLE, SETUP, ACCESS; psel, penable, paddr, pwrite, pwdata driven from registers.
REQ-015 IDLE: psel=0, penable=0; if any req bit is high, the winner is selected, its command is latched into paddr/pwrite/pwdata, and the FSM goes to SETUP on the next edge.
REQ-016 SETUP: psel=1, penable=0, held for exactly one cycle, then ACCESS.
REQ-017 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stay stable until exit.
REQ-018 ACCESS with pready=0: stay in ACCESS; the cycle count is unbounded without the timeout feature.
REQ-019 ACCESS with pready=1: done[grant]=1 combinationally in the same cycle, rdata=prdata, err=0, next state IDLE.
REQ-020 Minimum transfer is 3 cycles (IDLE sample, SETUP, ACCESS); there is no back-to-back SETUP from ACCESS.
REQ-021 The requester drops req in the cycle after done; a req still high in that cycle is treated as a new request.
REQ-022 Round-robin arbitration:
- Search starts at the requester after the last granted one, wrapping NUM_REQ-1 to 0.
- The pointer updates only on the IDLE to SETUP transition.
REQ-023 The grant is locked for the whole transfer; req changes on other lines during SETUP/ACCESS have no effect.
REQ-024 When no transfer completes, done is all-zero, rdata=0 and err=0.
REQ-025 pwdata is latched from req_wdata on reads as well; the slave ignores it.

Reset
REQ-026 preset=1 asynchronously forces:
- state to IDLE;
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
- round-robin pointer to 0 (requester 0 has highest priority first);
- timeout counter to 0.
REQ-027 Reset during SETUP or ACCESS aborts the transfer with no done pulse; the requester must re-request.

Configuration
REQ-028 Macro APB_ARB_TIMEOUT_EN defined:
- A wait counter runs in ACCESS and is cleared on entry.
- If pready is still 0 after TIMEOUT_CYCLES cycles in ACCESS, the transfer completes with done[grant]=1, err=1 and rdata=0, and the FSM returns to IDLE.
REQ-029 Macro APB_ARB_TIMEOUT_EN undefined: no counter logic, err tied to 0, and ACCESS waits indefinitely.

Structure
REQ-030 Package apb_arb_pkg holds:
- the state enum (IDLE, SETUP, ACCESS);
- constants APB_ADDR_W=3 and APB_DATA_W=16.
REQ-031 Sub-module rr_priority_picker takes the req vector and the pointer and returns a one-hot grant plus a valid bit; it is purely combinational.

Verification
REQ-032 Single write: req[0]=1, addr=3, wdata=16'hA5A5, pready=1 -> SETUP then ACCESS with paddr=3, pwrite=1, pwdata=A5A5; done[0] in the 3rd cycle; psel low next cycle.
REQ-033 Read with wait states: req[1]=1 read addr=5, pready low 4 ACCESS cycles, then high with prdata=16'h1234 -> penable held 5 cycles; done[1]=1 with rdata=1234 and err=0.
REQ-034 Contention: req=2'b11 held continuously -> grants alternate 0,1,0,1 over 4 transfers; no done ever goes to a non-granted requester.
REQ-035 Reset mid-ACCESS: assert preset during ACCESS -> psel and penable 0 immediately (async), no done, pointer back to 0, next grant goes to requester 0.
REQ-036 Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready held 0 -> after 16 ACCESS cycles done=1, err=1, rdata=0, FSM in IDLE; without the macro psel stays high after 100 cycles.
REQ-037 APB protocol checks run throughout all scenarios:
- no X on any output;
- psel/penable sequence legal at every cycle;
- paddr/pwdata stable across SETUP/ACCESS.
